mem_port_arbiter: RTL

- Shares one single-ported unified memory between the CPU instruction-fetch port and the CPU load/store port.
- Sits between cpu_riscv and the memory block in the minimal SoPC.
- Sequences multi-cycle memory transactions with an ack handshake and raises a stall request to the pipeline while either requester waits.
- Data accesses have priority; a starvation limit guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store, data first with a fetch starvation limit.
// Optional: define ARB_TIMEOUT_EN to abort BUSY transactions after TIMEOUT_CYCLES without an ack (err_o pulses).
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_ready_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_ready_o,
  output logic              stall_req_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic              ram_ack_i,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] starve_cnt;
  logic       grant_mem, grant_if, ack_done, abort;
  logic       timeout_hit;

  if (MAX_DATA_BURST < 1 || MAX_DATA_BURST > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mem_port_arbiter: MAX_DATA_BURST must be 1..15 and TIMEOUT_CYCLES at least 1");
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // to_cnt holds the number of BUSY cycles already completed, so the last allowed cycle sees TIMEOUT_CYCLES-1
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign err_o       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= abort;
      if (grant_mem || grant_if)
        to_cnt <= '0;
      else if (state_q == IF_BUSY || state_q == MEM_BUSY)
        to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  assign stall_req_o = (if_ce_i & ~if_ready_o) | (mem_ce_i & ~mem_ready_o);

  always_comb begin
    state_d   = state_q;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    ack_done  = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_ce_i && (!if_ce_i || starve_cnt < 4'(MAX_DATA_BURST))) begin
          grant_mem = 1'b1;
          state_d   = MEM_BUSY;
        end else if (if_ce_i) begin
          grant_if = 1'b1;
          state_d  = IF_BUSY;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        if (ram_ack_i) begin
          ack_done = 1'b1;
          state_d  = DONE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt  <= '0;
      ram_ce_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_sel_o   <= '0;
      ram_data_o  <= '0;
      if_inst_o   <= '0;
      mem_data_o  <= '0;
      if_ready_o  <= 1'b0;
      mem_ready_o <= 1'b0;
    end else begin
      if_ready_o  <= 1'b0;
      mem_ready_o <= 1'b0;

      // starve_cnt counts data grants issued while a fetch was kept waiting
      if (state_q == IDLE) begin
        if (grant_if || !if_ce_i)
          starve_cnt <= '0;
        else if (grant_mem && starve_cnt != 4'hF)
          starve_cnt <= starve_cnt + 4'd1;
      end

      if (grant_mem) begin
        ram_ce_o   <= 1'b1;
        ram_we_o   <= mem_we_i;
        ram_addr_o <= mem_addr_i;
        ram_sel_o  <= mem_sel_i;
        ram_data_o <= mem_data_i;
      end else if (grant_if) begin
        ram_ce_o   <= 1'b1;
        ram_we_o   <= 1'b0;
        ram_addr_o <= if_addr_i;
        ram_sel_o  <= 4'hF;
      end

      if (ack_done || abort) begin
        ram_ce_o <= 1'b0;
        if (state_q == IF_BUSY) begin
          if_inst_o  <= abort ? '0 : ram_data_i;
          if_ready_o <= 1'b1;
        end else begin
          mem_data_o  <= abort ? '0 : ram_data_i;
          mem_ready_o <= 1'b1;
        end
      end
    end
  end

endmodule
